four_full_adder: RTL and testbench

FOUR_FULL_ADDER -- requirements
Module: four_full_adder

---
 rtl/four_full_adder.sv | 82 ++++++++
 tb/tb_four_full_adder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/four_full_adder.sv
// 16-bit registered adder made of four rippled 4-bit slices, each slice built from 1-bit full adders.
// Reports the carry out of every nibble alongside the registered sum.

module full_adder (
    input  logic i_x,
    input  logic i_y,
    input  logic i_c,
    output logic o_s,
    output logic o_co
);
    logic w_p;

    assign w_p  = i_x ^ i_y;
    assign o_s  = w_p ^ i_c;
    assign o_co = (i_x & i_y) | (i_c & w_p);
endmodule

module ripple_adder4 (
    input  logic [3:0] i_x,
    input  logic [3:0] i_y,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic       o_co
);
    logic [4:0] w_c;

    assign w_c[0] = i_c;

    for (genvar k = 0; k < 4; k++) begin : g_bit
        full_adder u_fa (
            .i_x  (i_x[k]),
            .i_y  (i_y[k]),
            .i_c  (w_c[k]),
            .o_s  (o_s[k]),
            .o_co (w_c[k+1])
        );
    end

    assign o_co = w_c[4];
endmodule

module four_full_adder (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cIn,
    output logic [15:0] sumFinal,
    output logic [3:0]  cOutFinal
);
    // w_carry[i] is the carry into nibble i; w_carry[4] is bit 16 of the full sum
    logic [4:0]  w_carry;
    logic [15:0] w_sum;
    logic [15:0] r_sum_p0;
    logic [3:0]  r_cout_p0;

    assign w_carry[0] = cIn;

    for (genvar n = 0; n < 4; n++) begin : g_slice
        ripple_adder4 u_slice (
            .i_x  (a[4*n +: 4]),
            .i_y  (b[4*n +: 4]),
            .i_c  (w_carry[n]),
            .o_s  (w_sum[4*n +: 4]),
            .o_co (w_carry[n+1])
        );
    end

    // Output register stage: single-cycle latency, cleared asynchronously
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_sum_p0  <= 16'h0000;
            r_cout_p0 <= 4'b0000;
        end else begin
            r_sum_p0  <= w_sum;
            r_cout_p0 <= w_carry[4:1];
        end
    end

    assign sumFinal  = r_sum_p0;
    assign cOutFinal = r_cout_p0;
endmodule

// File: tb/tb_four_full_adder.sv
// Self-checking bench for four_full_adder: directed corner vectors, asynchronous reset and
// randomized back-to-back traffic compared against an arithmetic reference model.

module tb_four_full_adder;
    logic        Clk;
    logic        Rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        cIn;
    logic [15:0] sumFinal;
    logic [3:0]  cOutFinal;

    int checks;
    int errors;

    four_full_adder dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .a         (a),
        .b         (b),
        .cIn       (cIn),
        .sumFinal  (sumFinal),
        .cOutFinal (cOutFinal)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: carry out of nibble i is bit 4(i+1) of the sum of the low 4(i+1) bits
    function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c);
        int unsigned total;
        int unsigned mask;
        int unsigned part;
        logic [3:0]  co;
        total = int'(x) + int'(y) + int'(c);
        for (int i = 0; i < 4; i++) begin
            mask  = (32'd1 << (4 * (i + 1))) - 1;
            part  = (int'(x) & mask) + (int'(y) & mask) + int'(c);
            co[i] = part[4 * (i + 1)];
        end
        return {co, total[15:0]};
    endfunction

    task automatic apply_and_check(input logic [15:0] x, input logic [15:0] y,
                                   input logic c, input string name);
        logic [19:0] exp;
        @(negedge Clk);
        a   = x;
        b   = y;
        cIn = c;
        exp = model(x, y, c);
        @(posedge Clk);
        #1;
        checks++;
        if (sumFinal !== exp[15:0]) begin
            errors++;
            $display("FAIL %s sum: got %h expected %h", name, sumFinal, exp[15:0]);
        end
        checks++;
        if (cOutFinal !== exp[19:16]) begin
            errors++;
            $display("FAIL %s cout: got %b expected %b", name, cOutFinal, exp[19:16]);
        end
    endtask

    task automatic test_reset();
        a   = 16'h1234;
        b   = 16'h4321;
        cIn = 1'b1;
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (sumFinal !== 16'h0000 || cOutFinal !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: got %h/%b expected 0000/0000", sumFinal, cOutFinal);
        end
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic test_directed();
        apply_and_check(16'h0000, 16'h0000, 1'b0, "zero");
        apply_and_check(16'hFFFF, 16'hFFFF, 1'b0, "ffff_ffff_c0");
        checks++;
        if (sumFinal !== 16'hFFFE || cOutFinal !== 4'b1111) begin
            errors++;
            $display("FAIL const_ffff_c0: got %h/%b expected fffe/1111", sumFinal, cOutFinal);
        end
        apply_and_check(16'hFFFF, 16'hFFFF, 1'b1, "ffff_ffff_c1");
        checks++;
        if (sumFinal !== 16'hFFFF || cOutFinal !== 4'b1111) begin
            errors++;
            $display("FAIL const_ffff_c1: got %h/%b expected ffff/1111", sumFinal, cOutFinal);
        end
        apply_and_check(16'hAAAA, 16'h5555, 1'b1, "full_ripple");
        checks++;
        if (sumFinal !== 16'h0000 || cOutFinal !== 4'b1111) begin
            errors++;
            $display("FAIL const_ripple: got %h/%b expected 0000/1111", sumFinal, cOutFinal);
        end
        apply_and_check(16'h000F, 16'h0001, 1'b0, "nibble0_carry");
        apply_and_check(16'h0F00, 16'h0100, 1'b0, "nibble2_carry");
    endtask

    task automatic test_async_reset();
        logic [19:0] exp;
        apply_and_check(16'h0F0F, 16'hF0F0, 1'b0, "no_carry");
        checks++;
        if (sumFinal !== 16'hFFFF || cOutFinal !== 4'b0000) begin
            errors++;
            $display("FAIL const_no_carry: got %h/%b expected ffff/0000", sumFinal, cOutFinal);
        end
        @(negedge Clk);
        a   = 16'h8000;
        b   = 16'h8000;
        cIn = 1'b1;
        #1;
        Rst = 1'b1;
        #1;
        checks++;
        if (sumFinal !== 16'h0000 || cOutFinal !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: got %h/%b expected 0000/0000", sumFinal, cOutFinal);
        end
        @(posedge Clk);
        #1;
        checks++;
        if (sumFinal !== 16'h0000 || cOutFinal !== 4'b0000) begin
            errors++;
            $display("FAIL reset_held: got %h/%b expected 0000/0000", sumFinal, cOutFinal);
        end
        @(negedge Clk);
        Rst = 1'b0;
        exp = model(a, b, cIn);
        @(posedge Clk);
        #1;
        checks++;
        if ({cOutFinal, sumFinal} !== exp) begin
            errors++;
            $display("FAIL first_after_reset: got %b/%h expected %b/%h",
                     cOutFinal, sumFinal, exp[19:16], exp[15:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp;
        logic [19:0] prev;
        logic [15:0] x;
        logic [15:0] y;
        logic        c;
        prev = {cOutFinal, sumFinal};
        for (int i = 0; i < 200; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            c = 1'($urandom);
            @(negedge Clk);
            a   = x;
            b   = y;
            cIn = c;
            exp = model(x, y, c);
            #1;
            checks++;
            if ({cOutFinal, sumFinal} !== prev) begin
                errors++;
                $display("FAIL hold_%0d: got %b/%h expected %b/%h",
                         i, cOutFinal, sumFinal, prev[19:16], prev[15:0]);
            end
            @(posedge Clk);
            #1;
            checks++;
            if ({cOutFinal, sumFinal} !== exp) begin
                errors++;
                $display("FAIL random_%0d: a=%h b=%h c=%b got %b/%h expected %b/%h",
                         i, x, y, c, cOutFinal, sumFinal, exp[19:16], exp[15:0]);
            end
            prev = exp;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Rst    = 1'b1;
        a      = '0;
        b      = '0;
        cIn    = 1'b0;
        test_reset();
        test_directed();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
